branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; SHALL be a power of two, 4..256.
REQ-002 Parameter CTR_BITS, default 2, width of each saturating direction counter; SHALL be 2..4.
REQ-003 Parameter CNT_W, default 16, width of the statistics counters.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 IF_PC  in  32  fetch-stage PC, word aligned.
REQ-007 pred_hit  out  1  lookup hit: entry valid and tag match.
REQ-008 pred_taken  out  1  predicted taken for IF_PC.
REQ-009 pred_target  out  32  predicted next PC.
REQ-010 res_valid  in  1  a branch or jump resolves this cycle (ID stage).
REQ-011 res_PC  in  32  PC of the resolving instruction.
REQ-012 res_taken  in  1  actual direction.
REQ-013 res_target  in  32  actual taken target.
REQ-014 res_pred_taken  in  1  prediction carried down the pipe with the instruction.
REQ-015 res_pred_target  in  32  predicted PC carried down the pipe.
REQ-016 IF_flush  out  1  mispredict; flush IF/ID.
REQ-017 redirect_PC  out  32  corrected fetch PC, valid while IF_flush=1.
REQ-018 branch_count  out  CNT_W  resolved branches since reset.
REQ-019 miss_count  out  CNT_W  mispredicts since reset.

Function
REQ-020 Index SHALL be PC[IW+1:2] and tag PC[31:IW+2], where IW=log2(ENTRIES); each entry holds valid, tag, 32-bit target and a CTR_BITS-bit counter.
REQ-021 Lookup SHALL be combinational: pred_hit=valid&&tag match; pred_taken=pred_hit&&counter MSB; pred_target=pred_taken?entry target:IF_PC+4.
REQ-022 IF_flush SHALL be combinational: res_valid && (res_taken!=res_pred_taken || (res_taken && res_target!=res_pred_target)).
REQ-023 redirect_PC SHALL be res_taken?res_target:res_PC+4; its value is don't-care while IF_flush=0.
REQ-024 On res_valid with res_taken=1 and a hit: target is rewritten with res_target and the counter increments, saturating at all-ones.
REQ-025 On res_valid with res_taken=1 and a miss: the entry at the index is allocated or replaced (valid=1, new tag, res_target) and the counter is set to weakly taken (MSB=1, other bits 0).
REQ-026 On res_valid with res_taken=0 and a hit: the counter decrements, saturating at 0; the target is unchanged.
REQ-027 On res_valid with res_taken=0 and a miss: no entry is allocated or modified.
REQ-028 Updates SHALL take effect at the next edge: a lookup of the index being updated in the same cycle returns the pre-update contents.
REQ-029 branch_count SHALL increment on every res_valid cycle; miss_count SHALL increment on every IF_flush cycle; both saturate at all-ones and do not wrap.
REQ-030 Table writes SHALL be single-port: at most one entry is updated per cycle.

Reset
REQ-031 While reset=1: all valid bits cleared; all counters set to weakly not-taken (MSB=0, other bits 1); branch_count=0; miss_count=0.
REQ-032 A res_valid coinciding with reset=1 SHALL NOT modify any entry or counter.
REQ-033 Outputs after reset: pred_hit=0, pred_taken=0, pred_target=IF_PC+4; IF_flush depends only on res_* inputs.

Verification (ENTRIES=16, CTR_BITS=2)
REQ-034 Cold lookup: reset, then IF_PC=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044.
REQ-035 First taken: res_PC=0x40, res_taken=1, res_target=0x80, res_pred_taken=0 -> IF_flush=1, redirect_PC=0x80. Next cycle: miss_count=1, branch_count=1; IF_PC=0x40 -> pred_hit=1, pred_taken=1, pred_target=0x80.
REQ-036 Saturation: three correct taken resolutions at 0x40 -> counter 10->11->11, IF_flush=0 each. Then three not-taken resolutions -> counter 10, 01, 00; pred_taken=0 after the second; counter stays 00 after the third.
REQ-037 Alias: with 0x40 allocated, a taken resolution at res_PC=0x80 (same index 0, different tag) -> entry replaced; IF_PC=0x40 -> pred_hit=0. Also: a not-taken miss at 0xC0 allocates nothing.
REQ-038 Target change: hit at 0x40 predicting 0x80, res_taken=1, res_target=0x100, res_pred_target=0x80 -> IF_flush=1, redirect_PC=0x100; next lookup target=0x100.
REQ-039 Reset mid-operation: assert reset in the same cycle as a taken res_valid at 0x40 -> after reset, IF_PC=0x40 gives pred_hit=0, and both counts are 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and
// resolve-time statistics; lookup is combinational, updates land on the next edge.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      IF_PC,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             res_valid,
  input  logic [31:0]      res_PC,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  output logic             IF_flush,
  output logic [31:0]      redirect_PC,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic                valid_reg  [ENTRIES];
  logic [TW-1:0]       tag_reg    [ENTRIES];
  logic [31:0]         target_reg [ENTRIES];
  logic [CTR_BITS-1:0] ctr_reg    [ENTRIES];

  logic [CNT_W-1:0] branch_count_reg;
  logic [CNT_W-1:0] miss_count_reg;

  logic [IW-1:0] if_idx;
  logic [TW-1:0] if_tag;
  logic [IW-1:0] res_idx;
  logic [TW-1:0] res_tag;
  logic          res_hit;
  logic [CTR_BITS-1:0] res_ctr;

  logic                entry_write;
  logic [31:0]         target_next;
  logic [CTR_BITS-1:0] ctr_next;
  logic [ENTRIES-1:0]  entry_we;

  // Byte-offset bits of a word-aligned PC carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_PC[1:0], res_PC[1:0]};

  assign if_idx  = IF_PC[IW+1:2];
  assign if_tag  = IF_PC[31:IW+2];
  assign res_idx = res_PC[IW+1:2];
  assign res_tag = res_PC[31:IW+2];

  assign pred_hit    = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign pred_taken  = pred_hit && ctr_reg[if_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_reg[if_idx] : IF_PC + 32'd4;

  assign IF_flush    = res_valid && ((res_taken != res_pred_taken) ||
                                     (res_taken && (res_target != res_pred_target)));
  assign redirect_PC = res_taken ? res_target : res_PC + 32'd4;

  assign res_hit = valid_reg[res_idx] && (tag_reg[res_idx] == res_tag);
  assign res_ctr = ctr_reg[res_idx];

  // One write port: every field of the indexed entry is rewritten together.
  always_comb begin
    entry_write = 1'b0;
    target_next = target_reg[res_idx];
    ctr_next    = res_ctr;
    if (res_valid) begin
      if (res_taken) begin
        entry_write = 1'b1;
        target_next = res_target;
        if (res_hit)
          ctr_next = (&res_ctr) ? res_ctr : res_ctr + CTR_BITS'(1);
        else
          ctr_next = CTR_WEAK_T;
      end else if (res_hit) begin
        entry_write = 1'b1;
        ctr_next    = (res_ctr == '0) ? res_ctr : res_ctr - CTR_BITS'(1);
      end
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_we
    assign entry_we[gi] = entry_write && (res_idx == IW'(gi));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= CTR_WEAK_NT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (entry_we[i]) begin
          valid_reg[i]  <= 1'b1;
          tag_reg[i]    <= res_tag;
          target_reg[i] <= target_next;
          ctr_reg[i]    <= ctr_next;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      branch_count_reg <= '0;
      miss_count_reg   <= '0;
    end else begin
      if (res_valid && !(&branch_count_reg))
        branch_count_reg <= branch_count_reg + CNT_W'(1);
      if (IF_flush && !(&miss_count_reg))
        miss_count_reg <= miss_count_reg + CNT_W'(1);
    end
  end

  assign branch_count = branch_count_reg;
  assign miss_count   = miss_count_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed literal checks plus randomized traffic
// compared every cycle against a table-of-integers reference model.
module tb_branch_predictor;
  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int CNT_W    = 16;
  localparam int IW       = $clog2(ENTRIES);
  localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
  localparam int CTR_HALF = 1 << (CTR_BITS - 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [31:0]      IF_PC;
  logic             pred_hit;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             res_valid;
  logic [31:0]      res_PC;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             res_pred_taken;
  logic [31:0]      res_pred_target;
  logic             IF_flush;
  logic [31:0]      redirect_PC;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] miss_count;

  branch_predictor #(.ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .CNT_W(CNT_W)) dut (
    .clock(clk), .reset(reset), .IF_PC(IF_PC),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_PC(res_PC), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken),
    .res_pred_target(res_pred_target), .IF_flush(IF_flush),
    .redirect_PC(redirect_PC), .branch_count(branch_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;
  bit check_en;

  // Reference model: plain integers per table slot.
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int          m_branches;
  int          m_misses;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (2 + IW);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= CTR_HALF);
  endfunction

  function automatic logic [31:0] m_next_pc(input logic [31:0] pc);
    return m_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mispredict();
    return res_valid && ((res_taken != res_pred_taken) ||
                         (res_taken && (res_target != res_pred_target)));
  endfunction

  task automatic model_update();
    int i;
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = CTR_HALF - 1;
      end
      m_branches = 0;
      m_misses   = 0;
    end else if (res_valid) begin
      i = idx_of(res_PC);
      if (m_mispredict() && m_misses < CNT_MAX) m_misses++;
      if (m_branches < CNT_MAX) m_branches++;
      if (res_taken) begin
        if (m_hit(res_PC)) begin
          m_ctr[i] = (m_ctr[i] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[i] + 1;
        end else begin
          m_valid[i] = 1'b1;
          m_tag[i]   = tag_of(res_PC);
          m_ctr[i]   = CTR_HALF;
        end
        m_target[i] = res_target;
      end else if (m_hit(res_PC)) begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("pred_hit", 32'(pred_hit), 32'(m_hit(IF_PC)));
      chk("pred_taken", 32'(pred_taken), 32'(m_taken(IF_PC)));
      chk("pred_target", pred_target, m_next_pc(IF_PC));
      chk("IF_flush", 32'(IF_flush), 32'(m_mispredict()));
      if (m_mispredict())
        chk("redirect_PC", redirect_PC, res_taken ? res_target : res_PC + 32'd4);
      chk("branch_count", 32'(branch_count), 32'(m_branches));
      chk("miss_count", 32'(miss_count), 32'(m_misses));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    res_valid = 1'b1; res_PC = pc; res_taken = tk; res_target = tgt;
    res_pred_taken = ptk; res_pred_target = ptgt;
  endtask

  task automatic idle_res();
    res_valid = 1'b0; res_taken = 1'b0; res_pred_taken = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    IF_PC = pc;
    #2;
  endtask

  logic [31:0] rpc;

  initial begin
    tests = 0; failed = 0; check_en = 1'b0;
    m_branches = 0; m_misses = 0;
    for (int k = 0; k < ENTRIES; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = 0; m_target[k] = '0; m_ctr[k] = CTR_HALF - 1;
    end
    reset = 1'b1; IF_PC = 32'h40; res_PC = '0; res_target = '0; res_pred_target = '0;
    idle_res();
    cyc();
    check_en = 1'b1;
    cyc();
    reset = 1'b0;

    // Cold lookup
    look(32'h40);
    chk("cold_hit", 32'(pred_hit), 32'h0);
    chk("cold_taken", 32'(pred_taken), 32'h0);
    chk("cold_target", pred_target, 32'h44);
    chk("cold_branches", 32'(branch_count), 32'h0);

    // First taken resolution allocates
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44); #2;
    chk("first_flush", 32'(IF_flush), 32'h1);
    chk("first_redirect", redirect_PC, 32'h80);
    cyc(); idle_res(); look(32'h40);
    chk("alloc_hit", 32'(pred_hit), 32'h1);
    chk("alloc_taken", 32'(pred_taken), 32'h1);
    chk("alloc_target", pred_target, 32'h80);
    chk("alloc_misses", 32'(miss_count), 32'h1);
    chk("alloc_branches", 32'(branch_count), 32'h1);

    // Counter saturates high, then walks down and saturates at zero
    for (int n = 0; n < 3; n++) begin
      resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80); #2;
      chk("sat_up_flush", 32'(IF_flush), 32'h0);
      cyc();
    end
    resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80); cyc(); idle_res(); look(32'h40);
    chk("nt1_taken", 32'(pred_taken), 32'h1);
    resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80); cyc(); idle_res(); look(32'h40);
    chk("nt2_taken", 32'(pred_taken), 32'h0);
    resolve(32'h40, 1'b0, 32'h0, 1'b0, 32'h44); cyc();
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44); cyc(); idle_res(); look(32'h40);
    chk("floor_taken", 32'(pred_taken), 32'h0);
    chk("floor_hit", 32'(pred_hit), 32'h1);
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44); cyc(); idle_res(); look(32'h40);
    chk("recover_taken", 32'(pred_taken), 32'h1);

    // Target change on a hit
    resolve(32'h40, 1'b1, 32'h100, 1'b1, 32'h80); #2;
    chk("tchg_flush", 32'(IF_flush), 32'h1);
    chk("tchg_redirect", redirect_PC, 32'h100);
    cyc(); idle_res(); look(32'h40);
    chk("tchg_target", pred_target, 32'h100);

    // Alias replacement and a non-allocating not-taken miss
    resolve(32'h80, 1'b1, 32'h200, 1'b0, 32'h84); cyc(); idle_res(); look(32'h40);
    chk("alias_old_hit", 32'(pred_hit), 32'h0);
    look(32'h80);
    chk("alias_new_target", pred_target, 32'h200);
    resolve(32'hC0, 1'b0, 32'h0, 1'b0, 32'hC4); #2;
    chk("ntmiss_flush", 32'(IF_flush), 32'h0);
    cyc(); idle_res(); look(32'hC0);
    chk("ntmiss_hit", 32'(pred_hit), 32'h0);
    look(32'h80);
    chk("ntmiss_keep", 32'(pred_hit), 32'h1);

    // Reset coinciding with a taken resolution
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h44); reset = 1'b1; cyc();
    reset = 1'b0; idle_res(); look(32'h40);
    chk("rst_hit", 32'(pred_hit), 32'h0);
    chk("rst_branches", 32'(branch_count), 32'h0);
    chk("rst_misses", 32'(miss_count), 32'h0);
    cyc();

    // Randomized traffic over a small PC pool so entries collide and hit
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      IF_PC = {24'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 2'b00};
      rpc   = {24'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 2'b00};
      res_valid = ($urandom_range(0, 9) < 7);
      res_PC = rpc;
      res_taken = 1'($urandom_range(0, 1));
      res_target = {22'h0, 8'($urandom_range(0, 7) * 4 + 8'h10), 2'b00};
      if ($urandom_range(0, 3) != 0) begin
        res_pred_taken  = m_taken(rpc);
        res_pred_target = m_next_pc(rpc);
      end else begin
        res_pred_taken  = 1'($urandom_range(0, 1));
        res_pred_target = {22'h0, 8'($urandom_range(0, 7) * 4 + 8'h10), 2'b00};
      end
      if (res_valid && !reset)
        $display("[TB] res pc=%h taken=%0b tgt=%h ptaken=%0b ptgt=%h", res_PC, res_taken,
                 res_target, res_pred_taken, res_pred_target);
      cyc();
    end
    reset = 1'b0;
    idle_res();
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
